// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller.
//   slot_t  : one in-flight write tracked between EX and WB
//   state_t : halt-drain FSM states
//   DST_W   : stored destination width (covers register files up to 256 entries)
package hazard_pkg;

  localparam int unsigned DST_W = 8;

  localparam logic [DST_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [DST_W-1:0] dst;
    logic             load;
    logic             hlt;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//   ID decode info, EX branch/cancel info  : pipeline -> controller
//   stall/flush/bubble, forward selects,
//   halt flag, load-use stall counter      : controller -> pipeline
interface hazard_fwd_ctrl_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned SW    = 2,
  parameter int unsigned CNT_W = 16
);

  logic             id_valid;
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_we;
  logic [AW-1:0]    id_dst;
  logic             id_load;
  logic             id_hlt;
  logic             br_taken;
  logic             wr_cancel;

  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             bubble_idex;
  logic [SW-1:0]    fwd_a;
  logic [SW-1:0]    fwd_b;
  logic             hlt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_dst,
           id_load, id_hlt, br_taken, wr_cancel,
    input  stall_pc, stall_ifid, flush_ifid, bubble_idex, fwd_a, fwd_b,
           hlt, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_dst,
           id_load, id_hlt, br_taken, wr_cancel,
    output stall_pc, stall_ifid, flush_ifid, bubble_idex, fwd_a, fwd_b,
           hlt, stall_cnt
  );

endinterface

// File: rtl/fwd_select.sv
// Priority match of one EX source register against scoreboard slots 1..DEPTH-1.
//   slots    : scoreboard contents (slot 0 = EX, never a forwarding source)
//   src      : EX source register address
//   src_used : EX instruction actually reads src
//   sel_c    : youngest qualifying slot index, 0 when none qualifies
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned AW          = 4,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LD_FWD_SLOT = 2,
  parameter int unsigned SW          = $clog2(DEPTH)
) (
  input  slot_t         slots [DEPTH],
  input  logic [AW-1:0] src,
  input  logic          src_used,
  output logic [SW-1:0] sel_c
);

  // Scan oldest to youngest so the youngest match is the last one written.
  // Load data exists only from LD_FWD_SLOT onwards.
  always_comb begin
    sel_c = '0;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (slots[k].v && slots[k].we && src_used &&
          (slots[k].dst == DST_W'(src)) && (slots[k].dst != ZERO_REG) &&
          (!slots[k].load || (k >= int'(LD_FWD_SLOT))))
        sel_c = SW'(k);
    end
  end

  // Slot 0 and the halt markers play no part in forwarding.
  logic unused_bits;
  always_comb begin
    unused_bits = ^slots[0];
    for (int k = 1; k < int'(DEPTH); k++)
      unused_bits = unused_bits ^ slots[k].hlt;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard, forwarding and halt-drain controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of hazard_fwd_ctrl_if
//     in  : ID decode info, br_taken and wr_cancel from EX
//     out : stall_pc/stall_ifid/flush_ifid/bubble_idex (combinational),
//           fwd_a/fwd_b (from registered scoreboard), hlt, stall_cnt
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NREG        = 16,
  parameter int unsigned AW          = $clog2(NREG),
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LD_FWD_SLOT = 2,
  parameter int unsigned SW          = $clog2(DEPTH),
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_fwd_ctrl_if.slave bus
);

  slot_t            slots [DEPTH];
  logic [AW-1:0]    ex_rs;
  logic [AW-1:0]    ex_rt;
  logic             ex_rs_used;
  logic             ex_rt_used;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             luse_c;
  logic             advance_c;
  logic             take_id_c;
  logic             stall_c;
  logic             flush_c;
  logic             bubble_c;
  logic             halted_c;
  logic             count_stall_c;
  slot_t            id_slot_c;
  slot_t            slot0_adv_c;
  logic [SW-1:0]    sel_a_c;
  logic [SW-1:0]    sel_b_c;

  // Load-use: a load still too young to forward feeds a source read in ID.
  always_comb begin
    luse_c = 1'b0;
    for (int k = 0; k < int'(LD_FWD_SLOT) - 1; k++) begin
      if (slots[k].v && slots[k].load && slots[k].we && (slots[k].dst != ZERO_REG) &&
          ((bus.id_rs_used && (slots[k].dst == DST_W'(bus.id_rs))) ||
           (bus.id_rt_used && (slots[k].dst == DST_W'(bus.id_rt)))))
        luse_c = 1'b1;
    end
    luse_c = luse_c & bus.id_valid;
  end

  // Halt FSM and pipeline control; flush beats load-use and halt entry.
  always_comb begin
    state_nxt     = state;
    advance_c     = 1'b0;
    take_id_c     = 1'b0;
    stall_c       = 1'b0;
    flush_c       = 1'b0;
    bubble_c      = 1'b0;
    halted_c      = 1'b0;
    count_stall_c = 1'b0;
    unique case (state)
      ST_RUN: begin
        advance_c = 1'b1;
        if (bus.br_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (luse_c) begin
          stall_c       = 1'b1;
          bubble_c      = 1'b1;
          count_stall_c = 1'b1;
        end else begin
          take_id_c = bus.id_valid;
          if (bus.id_valid && bus.id_hlt)
            state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        advance_c = 1'b1;
        stall_c   = 1'b1;
        bubble_c  = 1'b1;
        // The halt reaches the WB slot on this same edge.
        if (slots[DEPTH-2].hlt)
          state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        halted_c = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Slot images for the next advance.
  always_comb begin
    id_slot_c      = '0;
    id_slot_c.v    = 1'b1;
    id_slot_c.we   = bus.id_we;
    id_slot_c.dst  = DST_W'(bus.id_dst);
    id_slot_c.load = bus.id_load;
    id_slot_c.hlt  = bus.id_hlt;
    slot0_adv_c    = slots[0];
    slot0_adv_c.we = slots[0].we & ~bus.wr_cancel;
  end

  // Scoreboard, EX source registers, FSM state and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++)
        slots[k] <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rs_used  <= 1'b0;
      ex_rt_used  <= 1'b0;
      state       <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (advance_c) begin
        for (int k = int'(DEPTH) - 1; k >= 2; k--)
          slots[k] <= slots[k-1];
        slots[1] <= slot0_adv_c;
        if (take_id_c) begin
          slots[0]   <= id_slot_c;
          ex_rs      <= bus.id_rs;
          ex_rt      <= bus.id_rt;
          ex_rs_used <= bus.id_rs_used;
          ex_rt_used <= bus.id_rt_used;
        end else begin
          slots[0]   <= '0;
          ex_rs      <= '0;
          ex_rt      <= '0;
          ex_rs_used <= 1'b0;
          ex_rt_used <= 1'b0;
        end
      end
      if (count_stall_c && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  fwd_select #(
    .AW          (AW),
    .DEPTH       (DEPTH),
    .LD_FWD_SLOT (LD_FWD_SLOT),
    .SW          (SW)
  ) u_fwd_a (
    .slots    (slots),
    .src      (ex_rs),
    .src_used (ex_rs_used),
    .sel_c    (sel_a_c)
  );

  fwd_select #(
    .AW          (AW),
    .DEPTH       (DEPTH),
    .LD_FWD_SLOT (LD_FWD_SLOT),
    .SW          (SW)
  ) u_fwd_b (
    .slots    (slots),
    .src      (ex_rt),
    .src_used (ex_rt_used),
    .sel_c    (sel_b_c)
  );

  // A frozen scoreboard must not steer EX operands.
  assign bus.fwd_a       = halted_c ? '0 : sel_a_c;
  assign bus.fwd_b       = halted_c ? '0 : sel_b_c;
  assign bus.stall_pc    = stall_c;
  assign bus.stall_ifid  = stall_c;
  assign bus.flush_ifid  = flush_c;
  assign bus.bubble_idex = bubble_c;
  assign bus.hlt         = halted_c;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl.
//   u_dut0 : default configuration (DEPTH=3, LD_FWD_SLOT=2)
//   u_dut1 : LD_FWD_SLOT=1, fed the same ID/EX stream as u_dut0
//   u_dut2 : DEPTH=16, LD_FWD_SLOT=15, long load-use stalls for counter saturation
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_fwd_ctrl_if #(.AW(4), .SW(2), .CNT_W(16)) if0 ();
  hazard_fwd_ctrl_if #(.AW(4), .SW(2), .CNT_W(16)) if1 ();
  hazard_fwd_ctrl_if #(.AW(4), .SW(4), .CNT_W(16)) if2 ();

  hazard_fwd_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  hazard_fwd_ctrl #(.LD_FWD_SLOT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  hazard_fwd_ctrl #(.DEPTH(16), .LD_FWD_SLOT(15)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if1.id_valid   = if0.id_valid;
  assign if1.id_rs      = if0.id_rs;
  assign if1.id_rt      = if0.id_rt;
  assign if1.id_rs_used = if0.id_rs_used;
  assign if1.id_rt_used = if0.id_rt_used;
  assign if1.id_we      = if0.id_we;
  assign if1.id_dst     = if0.id_dst;
  assign if1.id_load    = if0.id_load;
  assign if1.id_hlt     = if0.id_hlt;
  assign if1.br_taken   = if0.br_taken;
  assign if1.wr_cancel  = if0.wr_cancel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    if0.id_valid   = 1'b0;
    if0.id_rs      = '0;
    if0.id_rt      = '0;
    if0.id_rs_used = 1'b0;
    if0.id_rt_used = 1'b0;
    if0.id_we      = 1'b0;
    if0.id_dst     = '0;
    if0.id_load    = 1'b0;
    if0.id_hlt     = 1'b0;
    if0.br_taken   = 1'b0;
    if0.wr_cancel  = 1'b0;
  endtask

  task automatic idle2();
    if2.id_valid   = 1'b0;
    if2.id_rs      = '0;
    if2.id_rt      = '0;
    if2.id_rs_used = 1'b0;
    if2.id_rt_used = 1'b0;
    if2.id_we      = 1'b0;
    if2.id_dst     = '0;
    if2.id_load    = 1'b0;
    if2.id_hlt     = 1'b0;
    if2.br_taken   = 1'b0;
    if2.wr_cancel  = 1'b0;
  endtask

  // Present one valid instruction in ID of u_dut0/u_dut1.
  task automatic id0(input int rs, input int rsu, input int rt, input int rtu,
                     input int we, input int dst, input int ld, input int h);
    if0.id_valid   = 1'b1;
    if0.id_rs      = 4'(rs);
    if0.id_rs_used = 1'(rsu);
    if0.id_rt      = 4'(rt);
    if0.id_rt_used = 1'(rtu);
    if0.id_we      = 1'(we);
    if0.id_dst     = 4'(dst);
    if0.id_load    = 1'(ld);
    if0.id_hlt     = 1'(h);
  endtask

  task automatic do_reset();
    idle0();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    id0(1, 1, 2, 1, 1, 3, 1, 0);          // LW R3
    tick();
    id0(3, 1, 0, 0, 1, 4, 0, 0);          // reader of R3 -> one stall
    tick();
    idle0();
    #1;
    checks++;
    if (if0.stall_cnt !== 16'd1)
      $display("FAIL pre_reset_cnt: got %0d expected 1", if0.stall_cnt);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt});
    end
    checks++;
    if ({if0.fwd_a, if0.fwd_b} !== 4'b0) begin
      errors++;
      $display("FAIL reset_fwd: got %b expected 0000", {if0.fwd_a, if0.fwd_b});
    end
    checks++;
    if (if0.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", if0.stall_cnt);
    end
  endtask

  task automatic test_fwd_alu();
    do_reset();
    id0(1, 1, 2, 1, 1, 3, 0, 0);          // ADD R3,R1,R2
    tick();
    id0(3, 1, 2, 1, 1, 4, 0, 0);          // ADD R4,R3,R2
    #1;
    checks++;
    if ({if0.stall_pc, if0.bubble_idex} !== 2'b00) begin
      errors++;
      $display("FAIL alu_no_stall: got %b expected 00", {if0.stall_pc, if0.bubble_idex});
    end
    tick();
    idle0();
    #1;
    checks++;
    if (if0.fwd_a !== 2'd1) begin
      errors++;
      $display("FAIL fwd_a_adjacent: got %0d expected 1", if0.fwd_a);
    end
    checks++;
    if (if0.fwd_b !== 2'd0) begin
      errors++;
      $display("FAIL fwd_b_adjacent: got %0d expected 0", if0.fwd_b);
    end
    do_reset();
    id0(1, 1, 2, 1, 1, 3, 0, 0);          // ADD R3
    tick();
    id0(1, 1, 1, 1, 1, 8, 0, 0);          // independent ADD R8
    tick();
    id0(2, 1, 3, 1, 1, 4, 0, 0);          // ADD R4,R2,R3
    tick();
    idle0();
    #1;
    checks++;
    if (if0.fwd_b !== 2'd2) begin
      errors++;
      $display("FAIL fwd_b_gap: got %0d expected 2", if0.fwd_b);
    end
    checks++;
    if (if0.fwd_a !== 2'd0) begin
      errors++;
      $display("FAIL fwd_a_gap: got %0d expected 0", if0.fwd_a);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id0(1, 1, 0, 0, 1, 5, 1, 0);          // LW R5
    tick();
    id0(5, 1, 1, 1, 1, 6, 0, 0);          // ADD R6,R5,R1
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex} !== 4'b1101) begin
      errors++;
      $display("FAIL luse_stall: got %b expected 1101",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex});
    end
    checks++;
    if ({if1.stall_pc, if1.stall_ifid, if1.flush_ifid, if1.bubble_idex} !== 4'b0000) begin
      errors++;
      $display("FAIL luse_slot1_nostall: got %b expected 0000",
               {if1.stall_pc, if1.stall_ifid, if1.flush_ifid, if1.bubble_idex});
    end
    tick();
    #1;
    checks++;
    if ({if0.stall_pc, if0.bubble_idex} !== 2'b00) begin
      errors++;
      $display("FAIL luse_one_cycle: got %b expected 00", {if0.stall_pc, if0.bubble_idex});
    end
    checks++;
    if (if1.fwd_a !== 2'd1) begin
      errors++;
      $display("FAIL luse_slot1_fwd: got %0d expected 1", if1.fwd_a);
    end
    checks++;
    if (if0.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL luse_cnt: got %0d expected 1", if0.stall_cnt);
    end
    tick();
    idle0();
    #1;
    checks++;
    if (if0.fwd_a !== 2'd2) begin
      errors++;
      $display("FAIL luse_fwd_a: got %0d expected 2", if0.fwd_a);
    end
    checks++;
    if (if0.fwd_b !== 2'd0) begin
      errors++;
      $display("FAIL luse_fwd_b: got %0d expected 0", if0.fwd_b);
    end
  endtask

  task automatic test_r0_and_youngest();
    do_reset();
    id0(1, 1, 0, 0, 1, 0, 1, 0);          // LW R0
    tick();
    id0(0, 1, 0, 1, 1, 9, 0, 0);          // ADD R9,R0,R0
    #1;
    checks++;
    if ({if0.stall_pc, if0.bubble_idex} !== 2'b00) begin
      errors++;
      $display("FAIL r0_no_stall: got %b expected 00", {if0.stall_pc, if0.bubble_idex});
    end
    tick();
    idle0();
    #1;
    checks++;
    if ({if1.fwd_a, if1.fwd_b, if0.fwd_a, if0.fwd_b} !== 8'b0) begin
      errors++;
      $display("FAIL r0_no_fwd: got %b expected 00000000",
               {if1.fwd_a, if1.fwd_b, if0.fwd_a, if0.fwd_b});
    end
    do_reset();
    id0(1, 1, 2, 1, 1, 7, 0, 0);          // ADD R7 (older)
    tick();
    id0(3, 1, 4, 1, 1, 7, 0, 0);          // ADD R7 (younger)
    tick();
    id0(7, 1, 7, 1, 1, 10, 0, 0);         // ADD R10,R7,R7
    tick();
    idle0();
    #1;
    checks++;
    if (if0.fwd_a !== 2'd1) begin
      errors++;
      $display("FAIL youngest_a: got %0d expected 1", if0.fwd_a);
    end
    checks++;
    if (if0.fwd_b !== 2'd1) begin
      errors++;
      $display("FAIL youngest_b: got %0d expected 1", if0.fwd_b);
    end
  endtask

  task automatic test_wr_cancel();
    do_reset();
    id0(1, 1, 1, 1, 1, 2, 0, 0);          // conditional ADD R2
    tick();
    id0(2, 1, 2, 1, 1, 11, 0, 0);         // reader of R2
    if0.wr_cancel = 1'b1;                 // Z clear while the add is in EX
    tick();
    idle0();
    #1;
    checks++;
    if ({if0.fwd_a, if0.fwd_b} !== 4'b0) begin
      errors++;
      $display("FAIL cancel_no_fwd: got %b expected 0000", {if0.fwd_a, if0.fwd_b});
    end
  endtask

  task automatic test_branch_halt();
    do_reset();
    id0(0, 0, 0, 0, 0, 0, 0, 1);          // HLT
    if0.br_taken = 1'b1;
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex} !== 4'b0011) begin
      errors++;
      $display("FAIL br_flush: got %b expected 0011",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex});
    end
    tick();
    if0.br_taken = 1'b0;                  // HLT now without branch
    #1;
    checks++;
    if ({if0.stall_pc, if0.flush_ifid, if0.hlt} !== 3'b000) begin
      errors++;
      $display("FAIL br_stays_run: got %b expected 000", {if0.stall_pc, if0.flush_ifid, if0.hlt});
    end
    tick();
    idle0();
    if0.br_taken = 1'b1;                  // must be ignored while draining
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt} !== 5'b11010) begin
      errors++;
      $display("FAIL drain_1: got %b expected 11010",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt});
    end
    tick();
    idle0();
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt} !== 5'b11010) begin
      errors++;
      $display("FAIL drain_2: got %b expected 11010",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt});
    end
    tick();
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt} !== 5'b11011) begin
      errors++;
      $display("FAIL halted: got %b expected 11011",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex, if0.hlt});
    end
    tick();
    tick();
    #1;
    checks++;
    if (if0.hlt !== 1'b1) begin
      errors++;
      $display("FAIL halted_held: got %b expected 1", if0.hlt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.bubble_idex, if0.hlt} !== 4'b0000) begin
      errors++;
      $display("FAIL halt_reset: got %b expected 0000",
               {if0.stall_pc, if0.stall_ifid, if0.bubble_idex, if0.hlt});
    end
    tick();
    #1;
    checks++;
    if ({if0.stall_pc, if0.hlt} !== 2'b00) begin
      errors++;
      $display("FAIL halt_reset_run: got %b expected 00", {if0.stall_pc, if0.hlt});
    end
  endtask

  task automatic test_flush_vs_luse();
    do_reset();
    id0(1, 1, 0, 0, 1, 5, 1, 0);          // LW R5
    tick();
    id0(5, 1, 1, 1, 1, 6, 0, 0);          // reader of R5 ...
    if0.br_taken = 1'b1;                  // ... but branch taken in EX
    #1;
    checks++;
    if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex} !== 4'b0011) begin
      errors++;
      $display("FAIL flush_over_luse: got %b expected 0011",
               {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex});
    end
    tick();
    idle0();
    #1;
    checks++;
    if (if0.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_cnt: got %0d expected 0", if0.stall_cnt);
    end
  endtask

  // LW R5,(R5) held in ID: 14 stall cycles then one advance, repeating.
  task automatic test_saturate();
    do_reset();
    if2.id_valid   = 1'b1;
    if2.id_load    = 1'b1;
    if2.id_we      = 1'b1;
    if2.id_dst     = 4'd5;
    if2.id_rs      = 4'd5;
    if2.id_rs_used = 1'b1;
    repeat (14) tick();
    checks++;
    if (if2.stall_pc !== 1'b1) begin
      errors++;
      $display("FAIL deep_luse_edge: got %b expected 1", if2.stall_pc);
    end
    tick();
    checks++;
    if ({if2.stall_pc, if2.stall_cnt} !== {1'b0, 16'd14}) begin
      errors++;
      $display("FAIL deep_luse_release: got stall %b cnt %0d expected stall 0 cnt 14",
               if2.stall_pc, if2.stall_cnt);
    end
    repeat (72000 - 15) tick();
    checks++;
    if (if2.stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_saturate: got %h expected ffff", if2.stall_cnt);
    end
    idle2();
  endtask

  initial begin
    rst = 1'b1;
    idle0();
    idle2();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_r0_and_youngest();
    test_wr_cancel();
    test_branch_halt();
    test_flush_vs_luse();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
